regfile_gen: RTL

//  Parametrised register file for the CPU datapath.
//  - DEPTH = 2**ADDR_W words, DATA_W bits each; one write port and two registered read ports (A, B).
//  - Optional write-to-read bypass and optional hardwired-zero register 0.
//  - Built-in clear sequencer zeroes the array after reset and on request; BUSY flags it.
//  - Sits between the ALU result bus (RFIN) and the ALU operand inputs (A, B).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_if.sv | 30 +++
 rtl/regfile_clr_seq.sv | 57 +++++
 rtl/regfile_gen.sv | 104 ++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register file.
// Imported by the interface, the clear sequencer and the top level.
package regfile_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_if.sv
// Register file bus: write port, two read ports, clear request.
// master drives requests, slave returns read data and BUSY.
interface regfile_if #(
    parameter int DATA_W = regfile_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_pkg::ADDR_W_DEF
);

    logic              WE;
    logic [ADDR_W-1:0] WA;
    logic [DATA_W-1:0] RFIN;
    logic              RAE;
    logic [ADDR_W-1:0] RAA;
    logic              RBE;
    logic [ADDR_W-1:0] RBA;
    logic              CLR;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              BUSY;

    modport master (
        output WE, WA, RFIN, RAE, RAA, RBE, RBA, CLR,
        input  A, B, BUSY
    );

    modport slave (
        input  WE, WA, RFIN, RAE, RAA, RBE, RBA, CLR,
        output A, B, BUSY
    );

endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every address writing zero after reset
// and on a CLR request, holding BUSY high while it runs.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              CLR,
    output logic              BUSY,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    clr_state_t        state;
    logic [ADDR_W-1:0] ptr;

    // FSM: one word cleared per cycle, BUSY drops with the last one
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= CLEAR;
            ptr   <= '0;
            BUSY  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (CLR) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST) begin
                        state <= IDLE;
                        ptr   <= '0;
                        BUSY  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                    BUSY  <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = ptr;

endmodule

// File: rtl/regfile_gen.sv
// Parametrised register file: one write port, two registered
// read ports, optional bypass and hardwired-zero register 0.
module regfile_gen
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic      clock,
    input  logic      resetn,
    regfile_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clock    (clock),
        .resetn   (resetn),
        .CLR      (bus.CLR),
        .BUSY     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // write port mux: sequencer owns the array while clearing
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
        end else begin
            wr_en   = bus.WE &&
                      !(ZERO_REG != 0 && bus.WA == '0);
            wr_addr = bus.WA;
            wr_data = bus.RFIN;
        end
    end

    // array storage, deliberately not reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // read data selection: zero reg, then bypass, then array
    always_comb begin
        rd_a = mem[bus.RAA];
        rd_b = mem[bus.RBA];
        if (BYPASS != 0 && bus.WE && bus.WA == bus.RAA) begin
            rd_a = bus.RFIN;
        end
        if (BYPASS != 0 && bus.WE && bus.WA == bus.RBA) begin
            rd_b = bus.RFIN;
        end
        if (ZERO_REG != 0 && bus.RAA == '0) begin
            rd_a = '0;
        end
        if (ZERO_REG != 0 && bus.RBA == '0) begin
            rd_b = '0;
        end
    end

    // read registers, frozen while the clear runs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_q <= '0;
            b_q <= '0;
        end else if (!busy) begin
            if (bus.RAE) begin
                a_q <= rd_a;
            end
            if (bus.RBE) begin
                b_q <= rd_b;
            end
        end
    end

    assign bus.A    = a_q;
    assign bus.B    = b_q;
    assign bus.BUSY = busy;

endmodule
